// File: rtl/div_unit.sv
// div_unit -- multi-cycle radix-2 restoring divider for DIV / DIVU.
//
// One quotient bit is produced per clock.  Operands are latched when a
// request is accepted in FREE and ignored afterwards.  Signed operation
// divides magnitudes and fixes the signs at the end:
//   * the quotient is negated when the operand signs differ;
//   * the remainder takes the dividend's sign.
//
// Handshake (single description of the request/ready protocol):
//   The EX stage raises start_i with the operands and keeps it high.
//   ready_o rises once result_o is valid.  result_o stays stable while
//   start_i is high.  When EX drops start_i, the unit returns to FREE on
//   that edge and clears ready_o and result_o.  A new operation is
//   accepted only from FREE, so start_i must be low for at least one
//   cycle between operations.  annul_i aborts any operation and takes
//   precedence over start_i.
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous reset, active-low
//   signed_div_i  in   1 = DIV (two's complement), 0 = DIVU
//   opdata1_i     in   dividend
//   opdata2_i     in   divisor
//   start_i       in   request, held until the result is consumed
//   annul_i       in   abort / flush
//   result_o      out  {remainder, quotient}
//   ready_o       out  result_o valid
//   state_dbg_o   out  current FSM state (debug)
//
// Build option:
//   DIV_EARLY_OUT_EN -- when |op1| < |op2| (with a nonzero divisor), the
//   unit goes straight to END with quotient 0 and remainder op1.
//   Results are the same with or without this option; only latency changes.

module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic [1:0]         state_dbg_o
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_dvd;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   r_dvs;     // divisor magnitude
  logic [WIDTH-1:0]   r_rem;     // partial remainder
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;

  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;
  logic               w_accept;
  logic               w_early;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_quo_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_last;
  logic [WIDTH-1:0]   w_quo_fin;
  logic [WIDTH-1:0]   w_rem_fin;

  // Operand magnitudes.  Only signed operation takes the absolute value.
  // Note that -2^31 maps to 0x8000_0000, which is correct as an unsigned value.
  assign w_abs1   = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
  assign w_abs2   = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
  assign w_accept = start_i && !annul_i;

`ifdef DIV_EARLY_OUT_EN
  assign w_early  = (w_abs2 != '0) && (w_abs1 < w_abs2);
`else
  assign w_early  = 1'b0;
`endif

  // One restoring step.  The shifted remainder needs WIDTH+1 bits because
  // an unsigned divisor can be as large as 2^WIDTH-1.
  assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_dvs};
  assign w_qbit    = (w_shift >= {1'b0, r_dvs});
  assign w_rem_nxt = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_dvd[WIDTH-2:0], w_qbit};
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_last    = (w_cnt_nxt == CNT_W'(WIDTH));
  assign w_quo_fin = r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
  assign w_rem_fin = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FREE: begin
        if (w_accept) begin
          if (w_abs2 == '0)  w_state_nxt = S_BYZERO;
          else if (w_early)  w_state_nxt = S_END;
          else               w_state_nxt = S_ON;
        end
      end
      S_BYZERO: w_state_nxt = annul_i ? S_FREE : S_END;
      S_ON: begin
        if (annul_i)     w_state_nxt = S_FREE;
        else if (w_last) w_state_nxt = S_END;
      end
      S_END: begin
        if (annul_i || !start_i) w_state_nxt = S_FREE;
      end
      default: w_state_nxt = S_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FREE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        S_FREE: begin
          r_ready  <= 1'b0;
          r_result <= '0;
          r_cnt    <= '0;
          if (w_accept) begin
            r_dvd   <= w_abs1;
            r_dvs   <= w_abs2;
            r_rem   <= '0;
            r_neg_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            r_neg_r <= signed_div_i && opdata1_i[WIDTH-1];
            // Early-out result: the remainder is the original dividend
            // (signed value unchanged), and the quotient is zero.
            if (w_abs2 != '0 && w_early) r_result <= {opdata1_i, {WIDTH{1'b0}}};
          end
        end
        S_BYZERO: begin
          r_ready  <= 1'b0;
          r_result <= '0;
        end
        S_ON: begin
          if (annul_i) begin
            r_cnt    <= '0;
            r_ready  <= 1'b0;
            r_result <= '0;
          end else begin
            r_dvd <= w_quo_nxt;
            r_rem <= w_rem_nxt;
            r_cnt <= w_cnt_nxt;
            if (w_last) r_result <= {w_rem_fin, w_quo_fin};
          end
        end
        S_END: begin
          if (annul_i || !start_i) begin
            r_ready  <= 1'b0;
            r_result <= '0;
            r_cnt    <= '0;
          end else begin
            r_ready  <= 1'b1;
          end
        end
        default: begin
          r_ready  <= 1'b0;
          r_result <= '0;
        end
      endcase
    end
  end

  assign result_o    = r_result;
  assign ready_o     = r_ready;
  assign state_dbg_o = r_state;

endmodule
